// File: rtl/pipeline_control_unit_pkg.sv
// rtl/pipeline_control_unit_pkg.sv - shared state encodings and PC-select constants
// Purpose: core-wide definitions used by the pipeline control unit and its interface.
//   state_e  : RUN=0, MEM_WAIT=1, TRAP_FLUSH=2
//   pc_sel_t : PC_SEL_SEQ (PC+4), PC_SEL_BRANCH (branch target), PC_SEL_TRAP (trap vector)
package pipeline_control_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_MEM_WAIT   = 2'd1,
      ST_TRAP_FLUSH = 2'd2
   } state_e;

   typedef logic [1:0] pc_sel_t;

   localparam pc_sel_t PC_SEL_SEQ    = 2'b00;
   localparam pc_sel_t PC_SEL_BRANCH = 2'b01;
   localparam pc_sel_t PC_SEL_TRAP   = 2'b10;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// rtl/pipeline_control_unit_if.sv - hazard request / stage control bundle
// Purpose: groups the hazard/event requests and the per-stage control outputs.
//   Requests (core -> unit): hazard_stall_i, branch_taken_i, trap_req_i, dmem_req_i, dmem_ack_i
//   Controls (unit -> core): pc_en_o, *_en_o, *_flush_o, pc_sel_o, bus_err_o, stall_cnt_o
//   slave modport  : the control unit
//   master modport : the core datapath driving requests and consuming controls
interface pipeline_control_unit_if #(
   parameter int CNT_W = 32
);
   import pipeline_control_unit_pkg::*;

   logic             hazard_stall_i;
   logic             branch_taken_i;
   logic             trap_req_i;
   logic             dmem_req_i;
   logic             dmem_ack_i;

   logic             pc_en_o;
   logic             if_id_en_o;
   logic             id_ex_en_o;
   logic             ex_mem_en_o;
   logic             mem_wb_en_o;
   logic             if_id_flush_o;
   logic             id_ex_flush_o;
   logic             ex_mem_flush_o;
   logic             mem_wb_flush_o;
   pc_sel_t          pc_sel_o;
   logic             bus_err_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport slave (
      input  hazard_stall_i, branch_taken_i, trap_req_i, dmem_req_i, dmem_ack_i,
      output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
             pc_sel_o, bus_err_o, stall_cnt_o
   );

   modport master (
      output hazard_stall_i, branch_taken_i, trap_req_i, dmem_req_i, dmem_ack_i,
      input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
             pc_sel_o, bus_err_o, stall_cnt_o
   );

endinterface

// File: rtl/pipeline_control_unit_sat_counter.sv
// rtl/pipeline_control_unit_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts cycles where inc_i is high, holding at all-ones instead of wrapping.
//   clk_i   : clock
//   reset_i : asynchronous active-low reset, count -> 0
//   inc_i   : increment this cycle
//   clear_i : synchronous clear, wins over inc_i
//   count_o : current count
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         inc_i,
   input  logic         clear_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - pipeline motion arbiter for the 5-stage core
// Purpose: resolves trap / memory-wait / branch / load-use requests into stage enables,
//   bubble flushes and PC select; sequences multi-cycle memory waits with a bus timeout
//   and counts cycles in which the PC is held.
//   clk_i   : clock, all state on rising edge
//   reset_i : asynchronous active-low reset
//   bus     : slave side of pipeline_control_unit_if (requests in, controls out)
module pipeline_control_unit
   import pipeline_control_unit_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   pipeline_control_unit_if.slave   bus
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic    pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic    if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
   pc_sel_t pc_sel;
   logic    bus_err;

   // Action selected for this cycle; the output decode below is shared between
   // RUN and the ack cycle of MEM_WAIT so both honour branch/load-use identically.
   logic do_trap, do_freeze, do_advance, do_trap_flush;

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      do_trap       = 1'b0;
      do_freeze     = 1'b0;
      do_advance    = 1'b0;
      do_trap_flush = 1'b0;
      bus_err       = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (bus.trap_req_i) begin
               do_trap = 1'b1;
               state_d = ST_TRAP_FLUSH;
            end else if (bus.dmem_req_i && !bus.dmem_ack_i) begin
               do_freeze  = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               do_advance = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // A trap arriving while the bus is busy is deliberately ignored here.
            if (bus.dmem_ack_i) begin
               do_advance = 1'b1;
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
               do_trap    = 1'b1;
               bus_err    = 1'b1;
               state_d    = ST_TRAP_FLUSH;
               wait_cnt_d = '0;
            end else begin
               do_freeze  = 1'b1;
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_TRAP_FLUSH: begin
            do_trap_flush = 1'b1;
            state_d       = ST_RUN;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if_id_fl  = 1'b0;
      id_ex_fl  = 1'b0;
      ex_mem_fl = 1'b0;
      mem_wb_fl = 1'b0;
      pc_sel    = PC_SEL_SEQ;

      if (do_trap) begin
         pc_sel    = PC_SEL_TRAP;
         if_id_fl  = 1'b1;
         id_ex_fl  = 1'b1;
         ex_mem_fl = 1'b1;
      end else if (do_freeze) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
         // Bubble into WB so the stalled instruction is not written back twice.
         mem_wb_fl = 1'b1;
      end else if (do_trap_flush) begin
         // Kills the instruction fetched from the pre-trap PC.
         if_id_fl = 1'b1;
      end else if (do_advance) begin
         if (bus.branch_taken_i) begin
            pc_sel   = PC_SEL_BRANCH;
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
         end else if (bus.hazard_stall_i) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_fl = 1'b1;
         end
      end

      if (!reset_i) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
         if_id_fl  = 1'b1;
         id_ex_fl  = 1'b1;
         ex_mem_fl = 1'b1;
         mem_wb_fl = 1'b1;
         pc_sel    = PC_SEL_SEQ;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (!pc_en),
      .clear_i (1'b0),
      .count_o (bus.stall_cnt_o)
   );

   assign bus.pc_en_o        = pc_en;
   assign bus.if_id_en_o     = if_id_en;
   assign bus.id_ex_en_o     = id_ex_en;
   assign bus.ex_mem_en_o    = ex_mem_en;
   assign bus.mem_wb_en_o    = mem_wb_en;
   assign bus.if_id_flush_o  = if_id_fl;
   assign bus.id_ex_flush_o  = id_ex_fl;
   assign bus.ex_mem_flush_o = ex_mem_fl;
   assign bus.mem_wb_flush_o = mem_wb_fl;
   assign bus.pc_sel_o       = pc_sel;
   assign bus.bus_err_o      = bus_err & reset_i;

endmodule
